// File: rtl/ps2_dir_decoder_if.sv
// -----------------------------------------------------------------------------
// ps2_dir_decoder_if
//   Bundles the signals between the PS/2 receiver, the scan-code decoder and
//   game_logic.
//   slave  : the decoder side (consumes bytes and acks, drives commands)
//   master : the environment side (drives bytes and acks, observes commands)
//   Signals:
//     ps2_valid_i  one-cycle strobe, ps2_data_i holds a new byte
//     ps2_data_i   received scan-code byte
//     dir_ack_i    game_logic consumed the pending direction
//     dir_o        pending direction 00 up, 01 down, 10 left, 11 right
//     dir_valid_o  dir_o holds an unconsumed direction
//     held_o       keys down: [0]up [1]down [2]left [3]right
//     pause_o      pause level
//     start_o      one-cycle start pulse
//     err_o        one-cycle error pulse
// -----------------------------------------------------------------------------
interface ps2_dir_decoder_if;
  logic       ps2_valid_i;
  logic [7:0] ps2_data_i;
  logic       dir_ack_i;
  logic [1:0] dir_o;
  logic       dir_valid_o;
  logic [3:0] held_o;
  logic       pause_o;
  logic       start_o;
  logic       err_o;

  modport slave (
    input  ps2_valid_i, ps2_data_i, dir_ack_i,
    output dir_o, dir_valid_o, held_o, pause_o, start_o, err_o
  );

  modport master (
    output ps2_valid_i, ps2_data_i, dir_ack_i,
    input  dir_o, dir_valid_o, held_o, pause_o, start_o, err_o
  );
endinterface

// File: rtl/ps2_dir_decoder.sv
// -----------------------------------------------------------------------------
// ps2_dir_decoder
//   Turns PS/2 set-2 scan-code bytes (with E0 / F0 prefixes) into Pac-Man
//   commands: a pending direction with valid/ack handshake, a pause toggle,
//   a start pulse and a held-key mask. Typematic repeats are filtered with
//   per-key held bits so game_logic only sees clean press events.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    ps2_dir_decoder_if.slave (byte stream in, commands out)
//   Parameters:
//     TIMEOUT_CYC  cycles allowed between a prefix and the following byte
//     CNT_W        width of the prefix timeout counter
// -----------------------------------------------------------------------------
module ps2_dir_decoder #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  ps2_dir_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;
  typedef enum logic [2:0] {K_NONE, K_UP, K_DOWN, K_LEFT, K_RIGHT, K_P, K_ENTER} key_e;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Plain and extended codes map onto the same keys, so they share held bits.
  function automatic key_e decode(input logic [7:0] code, input logic ext);
    key_e k;
    k = K_NONE;
    if (ext) begin
      case (code)
        8'h75:   k = K_UP;
        8'h72:   k = K_DOWN;
        8'h6B:   k = K_LEFT;
        8'h74:   k = K_RIGHT;
        default: k = K_NONE;
      endcase
    end else begin
      case (code)
        8'h1D:   k = K_UP;
        8'h1B:   k = K_DOWN;
        8'h1C:   k = K_LEFT;
        8'h23:   k = K_RIGHT;
        8'h4D:   k = K_P;
        8'h5A:   k = K_ENTER;
        default: k = K_NONE;
      endcase
    end
    return k;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             valid_q, valid_d;
  logic [3:0]       held_q, held_d;
  logic             p_held_q, p_held_d;
  logic             ent_held_q, ent_held_d;
  logic             pause_q, pause_d;
  logic             start_q, start_d;
  logic             err_q, err_d;

  logic       is_make;
  logic       is_brk;
  logic       is_ext;
  key_e       key;
  logic [1:0] dir_idx;

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    valid_d    = valid_q;
    held_d     = held_q;
    p_held_d   = p_held_q;
    ent_held_d = ent_held_q;
    pause_d    = pause_q;
    start_d    = 1'b0;
    err_d      = 1'b0;
    is_make    = 1'b0;
    is_brk     = 1'b0;
    is_ext     = 1'b0;
    dir_idx    = 2'b00;

    // Ack clears the pending direction; a make in the same cycle re-sets it
    // below, so the newest direction wins.
    if (bus.dir_ack_i) valid_d = 1'b0;

    if (bus.ps2_valid_i) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (bus.ps2_data_i == PFX_EXT)      state_d = EXT;
          else if (bus.ps2_data_i == PFX_BRK) state_d = BRK;
          else                                is_make = 1'b1;
        end
        EXT: begin
          if (bus.ps2_data_i == PFX_BRK)      state_d = EXT_BRK;
          else if (bus.ps2_data_i == PFX_EXT) err_d   = 1'b1;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if (bus.ps2_data_i == PFX_EXT || bus.ps2_data_i == PFX_BRK) begin
            err_d = 1'b1;
          end else begin
            is_brk = 1'b1;
            is_ext = (state_q == EXT_BRK);
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A prefix left dangling too long is abandoned and flagged.
      if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    key = decode(bus.ps2_data_i, is_ext);
    case (key)
      K_UP:    dir_idx = 2'b00;
      K_DOWN:  dir_idx = 2'b01;
      K_LEFT:  dir_idx = 2'b10;
      K_RIGHT: dir_idx = 2'b11;
      default: dir_idx = 2'b00;
    endcase

    case (key)
      K_UP, K_DOWN, K_LEFT, K_RIGHT: begin
        // A make with the held bit already set is a typematic repeat.
        if (is_make && !held_q[dir_idx]) begin
          held_d[dir_idx] = 1'b1;
          dir_d           = dir_idx;
          valid_d         = 1'b1;
        end else if (is_brk) begin
          held_d[dir_idx] = 1'b0;
        end
      end
      K_P: begin
        if (is_make && !p_held_q) begin
          p_held_d = 1'b1;
          pause_d  = ~pause_q;
        end else if (is_brk) begin
          p_held_d = 1'b0;
        end
      end
      K_ENTER: begin
        if (is_make && !ent_held_q) begin
          ent_held_d = 1'b1;
          start_d    = 1'b1;
        end else if (is_brk) begin
          ent_held_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 2'b00;
      valid_q    <= 1'b0;
      held_q     <= 4'b0000;
      p_held_q   <= 1'b0;
      ent_held_q <= 1'b0;
      pause_q    <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      p_held_q   <= p_held_d;
      ent_held_q <= ent_held_d;
      pause_q    <= pause_d;
      start_q    <= start_d;
      err_q      <= err_d;
    end
  end

  assign bus.dir_o       = dir_q;
  assign bus.dir_valid_o = valid_q;
  assign bus.held_o      = held_q;
  assign bus.pause_o     = pause_q;
  assign bus.start_o     = start_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_dir_decoder
//   Directed bench for ps2_dir_decoder. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle after the rising
//   edge that registered them. The prefix timeout is shortened to keep the
//   run brief; the counting behaviour is the same as with the full value.
// -----------------------------------------------------------------------------
module tb_ps2_dir_decoder;

  localparam int TO = 1000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   rises;
  logic valid_prev;

  ps2_dir_decoder_if bus ();

  ps2_dir_decoder #(.TIMEOUT_CYC(TO), .CNT_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges of dir_valid_o as seen at the sampling edge.
  always @(negedge clk) begin
    if (bus.dir_valid_o && !valid_prev) rises = rises + 1;
    valid_prev = bus.dir_valid_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.ps2_valid_i = 1'b1;
    bus.ps2_data_i  = b;
    @(negedge clk);
    bus.ps2_valid_i = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.dir_ack_i = 1'b1;
    @(negedge clk);
    bus.dir_ack_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".dir"},   32'(bus.dir_o),       32'h0);
    check({tag, ".valid"}, 32'(bus.dir_valid_o), 32'h0);
    check({tag, ".held"},  32'(bus.held_o),      32'h0);
    check({tag, ".pause"}, 32'(bus.pause_o),     32'h0);
    check({tag, ".start"}, 32'(bus.start_o),     32'h0);
    check({tag, ".err"},   32'(bus.err_o),       32'h0);
  endtask

  initial begin
    int first_err;
    int err_pulses;
    n_checks        = 0;
    n_pass          = 0;
    rises           = 0;
    valid_prev      = 1'b0;
    rst_n           = 1'b0;
    bus.ps2_valid_i = 1'b0;
    bus.ps2_data_i  = 8'h00;
    bus.dir_ack_i   = 1'b0;

    // 1: reset state, then reset in the middle of an E0 sequence.
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    send(8'h1D);
    send(8'h4D);
    check("pre_rst.valid", 32'(bus.dir_valid_o), 32'h1);
    check("pre_rst.pause", 32'(bus.pause_o),     32'h1);
    send(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h75);
    check("post_rst75.held",  32'(bus.held_o),      32'h0);
    check("post_rst75.valid", 32'(bus.dir_valid_o), 32'h0);

    // 2: extended up make, ack, extended break.
    send(8'hE0);
    check("e0.valid", 32'(bus.dir_valid_o), 32'h0);
    send(8'h75);
    check("up.dir",   32'(bus.dir_o),       32'h0);
    check("up.valid", 32'(bus.dir_valid_o), 32'h1);
    check("up.held",  32'(bus.held_o),      32'h1);
    ack();
    check("up_ack.valid", 32'(bus.dir_valid_o), 32'h0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_brk.held",  32'(bus.held_o),      32'h0);
    check("up_brk.valid", 32'(bus.dir_valid_o), 32'h0);

    // 3: overwrite while pending, then ack colliding with a new make.
    send(8'h1C);
    check("left.dir",  32'(bus.dir_o),  32'h2);
    check("left.held", 32'(bus.held_o), 32'h4);
    send(8'h23);
    check("right.dir",   32'(bus.dir_o),       32'h3);
    check("right.valid", 32'(bus.dir_valid_o), 32'h1);
    check("right.held",  32'(bus.held_o),      32'hC);
    @(negedge clk);
    bus.ps2_valid_i = 1'b1;
    bus.ps2_data_i  = 8'h1B;
    bus.dir_ack_i   = 1'b1;
    @(negedge clk);
    bus.ps2_valid_i = 1'b0;
    bus.dir_ack_i   = 1'b0;
    check("coll.dir",   32'(bus.dir_o),       32'h1);
    check("coll.valid", 32'(bus.dir_valid_o), 32'h1);
    check("coll.held",  32'(bus.held_o),      32'hE);
    ack();
    check("coll_ack.valid", 32'(bus.dir_valid_o), 32'h0);
    ack();
    check("idle_ack.valid", 32'(bus.dir_valid_o), 32'h0);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h23);
    send(8'hF0); send(8'h1B);
    check("rel.held", 32'(bus.held_o), 32'h0);

    // 4: typematic repeats of W.
    rises = 0;
    send(8'h1D); send(8'h1D); send(8'h1D);
    check("typ.rises", 32'(rises), 32'h1);
    check("typ.dir",   32'(bus.dir_o), 32'h0);
    ack();
    send(8'h1D);
    check("typ_rep.valid", 32'(bus.dir_valid_o), 32'h0);
    send(8'hF0); send(8'h1D);
    check("typ_brk.held", 32'(bus.held_o), 32'h0);
    send(8'h1D);
    check("typ_new.valid", 32'(bus.dir_valid_o), 32'h1);
    check("typ_new.dir",   32'(bus.dir_o),       32'h0);
    check("typ_new.held",  32'(bus.held_o),      32'h1);
    ack();
    send(8'hF0); send(8'h1D);

    // 5: dangling F0 times out exactly TO cycles after the prefix edge.
    send(8'hF0);
    first_err  = 0;
    err_pulses = 0;
    for (int n = 1; n <= TO + 10; n++) begin
      @(negedge clk);
      if (bus.err_o) begin
        if (first_err == 0) first_err = n;
        err_pulses = err_pulses + 1;
      end
    end
    check("to.cycle",  32'(first_err),  32'(TO));
    check("to.pulses", 32'(err_pulses), 32'h1);
    send(8'h23);
    check("to_make.dir",   32'(bus.dir_o),       32'h3);
    check("to_make.valid", 32'(bus.dir_valid_o), 32'h1);
    check("to_make.held",  32'(bus.held_o),      32'h8);
    ack();
    send(8'hF0); send(8'h23);

    // 6: pause, start, and a doubled E0 prefix.
    send(8'h4D);
    check("p1.pause", 32'(bus.pause_o), 32'h1);
    send(8'h4D);
    check("p_rep.pause", 32'(bus.pause_o), 32'h1);
    send(8'hF0); send(8'h4D); send(8'h4D);
    check("p2.pause", 32'(bus.pause_o), 32'h0);
    send(8'h5A);
    check("start.hi", 32'(bus.start_o), 32'h1);
    @(negedge clk);
    check("start.lo", 32'(bus.start_o), 32'h0);
    send(8'h5A);
    check("start_rep", 32'(bus.start_o), 32'h0);
    send(8'hE0);
    check("e0e0.first", 32'(bus.err_o), 32'h0);
    send(8'hE0);
    check("e0e0.err", 32'(bus.err_o), 32'h1);
    @(negedge clk);
    check("e0e0.err_lo", 32'(bus.err_o), 32'h0);
    send(8'h75);
    check("e0e0.ext_dir",   32'(bus.dir_o),       32'h0);
    check("e0e0.ext_valid", 32'(bus.dir_valid_o), 32'h1);
    check("e0e0.ext_held",  32'(bus.held_o),      32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
